// File: rtl/hex_digit_arbiter_if.sv
// Purpose : bundles the requester side and the display side of hex_digit_arbiter.
// Latency : n/a (signal bundle only).
// Backpressure: none; req is level-sensitive and grant/digit/off are plain registered outputs.
//
// Signals: req (request per source), data (nibble per source, source i at data[4*i+3:4*i]),
//          hold (freeze rotation), grant (one-hot owner), digit (owner nibble),
//          off (blank digit), switch_pulse (grant changed this cycle).
// master = requester/display environment, slave = arbiter.
interface hex_digit_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [4*N_REQ-1:0] data;
    logic               hold;
    logic [N_REQ-1:0]   grant;
    logic [3:0]         digit;
    logic               off;
    logic               switch_pulse;

    modport master (
        output req, data, hold,
        input  grant, digit, off, switch_pulse
    );

    modport slave (
        input  req, data, hold,
        output grant, digit, off, switch_pulse
    );
endinterface

// File: rtl/hex_digit_arbiter.sv
// Purpose : round-robin time-share of one seven-seg digit among N_REQ nibble sources, fixed dwell per grant.
// Latency : grant/digit/off registered, 1 cycle after req/data are sampled.
// Backpressure: none; hold freezes dwell and grant, an owner dropping req releases the digit at once.
//
// Ports: clock, reset_n (synchronous, active-low), bus (hex_digit_arbiter_if.slave):
//        req/data/hold in, grant/digit/off/switch_pulse out.
// Option: define ARB_BLANK_GAP_EN to blank the digit for GAP_CYCLES between two different owners.
module hex_digit_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DWELL_CYCLES = 50000000,
    parameter int GAP_CYCLES   = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    hex_digit_arbiter_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DW = $clog2(DWELL_CYCLES) + 1;

`ifdef ARB_BLANK_GAP_EN
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
    logic [GW-1:0] gap_cnt;
`else
    typedef enum logic [1:0] {IDLE, SHOW} state_t;
`endif

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [DW-1:0] dwell;

    logic [PW-1:0]    cand;
    logic [PW-1:0]    win_idx;
    logic             win_vld;
    logic [PW-1:0]    nxt_ptr;
    logic [N_REQ-1:0] win_onehot;
    logic             rearb;

    // First requester at or after ptr. Because ptr sits just past the current
    // owner, the owner is searched last and only wins when nobody else asks.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PW'((int'(ptr) + k) % N_REQ);
            if (!win_vld && bus.req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign nxt_ptr    = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;

    // Owner drop wins over hold; dwell expiry only counts when not held.
    assign rearb = !bus.req[owner] || ((dwell == '0) && !bus.hold);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= IDLE;
            bus.grant        <= '0;
            bus.digit        <= '0;
            bus.off          <= 1'b1;
            bus.switch_pulse <= 1'b0;
            ptr              <= '0;
            owner            <= '0;
            dwell            <= '0;
`ifdef ARB_BLANK_GAP_EN
            gap_cnt          <= '0;
`endif
        end else begin
            bus.switch_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state            <= SHOW;
                        bus.grant        <= win_onehot;
                        bus.digit        <= bus.data[4*win_idx +: 4];
                        bus.off          <= 1'b0;
                        bus.switch_pulse <= 1'b1;
                        owner            <= win_idx;
                        ptr              <= nxt_ptr;
                        dwell            <= DW'(DWELL_CYCLES - 1);
                    end
                end
                SHOW: begin
                    bus.digit <= bus.data[4*owner +: 4];
                    if (rearb) begin
                        if (!win_vld) begin
                            state            <= IDLE;
                            bus.grant        <= '0;
                            bus.off          <= 1'b1;
                            bus.switch_pulse <= 1'b1;
`ifdef ARB_BLANK_GAP_EN
                        end else if (win_idx != owner) begin
                            // Different owner next: blank first; the winner is
                            // re-chosen at the end of the gap from the same ptr.
                            state            <= GAP;
                            bus.grant        <= '0;
                            bus.off          <= 1'b1;
                            bus.switch_pulse <= 1'b1;
                            gap_cnt          <= GW'(GAP_CYCLES - 1);
`endif
                        end else begin
                            bus.grant        <= win_onehot;
                            bus.digit        <= bus.data[4*win_idx +: 4];
                            bus.switch_pulse <= (win_idx != owner);
                            owner            <= win_idx;
                            ptr              <= nxt_ptr;
                            dwell            <= DW'(DWELL_CYCLES - 1);
                        end
                    end else if (!bus.hold) begin
                        // rearb is clear here, so dwell is non-zero: no wrap.
                        dwell <= dwell - 1'b1;
                    end
                end
`ifdef ARB_BLANK_GAP_EN
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (win_vld) begin
                        state            <= SHOW;
                        bus.grant        <= win_onehot;
                        bus.digit        <= bus.data[4*win_idx +: 4];
                        bus.off          <= 1'b0;
                        bus.switch_pulse <= 1'b1;
                        owner            <= win_idx;
                        ptr              <= nxt_ptr;
                        dwell            <= DW'(DWELL_CYCLES - 1);
                    end else begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hex_digit_arbiter.sv
module tb_hex_digit_arbiter;
    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    hex_digit_arbiter_if #(.N_REQ(4)) bus ();

    hex_digit_arbiter #(
        .N_REQ        (4),
        .DWELL_CYCLES (4),
        .GAP_CYCLES   (2)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [3:0] grant;
        logic       off;
        logic [3:0] digit;
        logic       chk_digit;
        logic       pulse;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_id = 0;

    // Apply one cycle of stimulus and queue what the outputs must be after that edge.
    task automatic cyc(input logic rn, input logic [3:0] r, input logic [15:0] d, input logic h,
                       input logic [3:0] eg, input logic [3:0] ed, input logic cd, input logic ep);
        exp_t e;
        @(negedge clock);
        reset_n  = rn;
        bus.req  = r;
        bus.data = d;
        bus.hold = h;
        @(posedge clock);
        e.grant     = eg;
        e.off       = (eg == 4'b0000);
        e.digit     = ed;
        e.chk_digit = cd;
        e.pulse     = ep;
        e.id        = step_id;
        step_id++;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are registered, so every cycle is a presented response.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (bus.grant !== e.grant) begin
                n_fail++;
                $display("FAIL step%0d grant: got %b want %b", e.id, bus.grant, e.grant);
            end
            n_tests++;
            if (bus.off !== e.off) begin
                n_fail++;
                $display("FAIL step%0d off: got %b want %b", e.id, bus.off, e.off);
            end
            n_tests++;
            if (bus.switch_pulse !== e.pulse) begin
                n_fail++;
                $display("FAIL step%0d switch_pulse: got %b want %b", e.id, bus.switch_pulse, e.pulse);
            end
            if (e.chk_digit) begin
                n_tests++;
                if (bus.digit !== e.digit) begin
                    n_fail++;
                    $display("FAIL step%0d digit: got %h want %h", e.id, bus.digit, e.digit);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        bus.req  = '0;
        bus.data = 16'h4321;
        bus.hold = 1'b0;

        // Reset, then idle with no requests.
        repeat (2)  cyc(1'b0, 4'b0000, 16'h4321, 1'b0, 4'b0000, 4'h0, 1'b1, 1'b0);
        repeat (10) cyc(1'b1, 4'b0000, 16'h4321, 1'b0, 4'b0000, 4'h0, 1'b1, 1'b0);

`ifndef ARB_BLANK_GAP_EN
        // Full rotation over four requesters, 4 cycles each.
        for (int g = 0; g < 4; g++)
            for (int c = 0; c < 4; c++)
                cyc(1'b1, 4'b1111, 16'h4321, 1'b0, 4'(1 << g), 4'(g + 1), 1'b1, c == 0);
        cyc(1'b1, 4'b1111, 16'h4321, 1'b0, 4'b0001, 4'h1, 1'b1, 1'b1);

        // Hold freezes owner 0 with 3 dwell cycles left, then they run out.
        repeat (20) cyc(1'b1, 4'b1111, 16'h4321, 1'b1, 4'b0001, 4'h1, 1'b1, 1'b0);
        repeat (3)  cyc(1'b1, 4'b1111, 16'h4321, 1'b0, 4'b0001, 4'h1, 1'b1, 1'b0);
        cyc(1'b1, 4'b1111, 16'h4321, 1'b0, 4'b0010, 4'h2, 1'b1, 1'b1);

        // Owner 1 drops after one dwell cycle; source 2 takes over next cycle.
        cyc(1'b1, 4'b0110, 16'h4321, 1'b0, 4'b0010, 4'h2, 1'b1, 1'b0);
        cyc(1'b1, 4'b0100, 16'h4321, 1'b0, 4'b0100, 4'h3, 1'b1, 1'b1);

        // Sole requester re-granted silently; data change shows one cycle later.
        for (int c = 0; c < 8; c++)
            cyc(1'b1, 4'b0100, (c < 4) ? 16'h4321 : 16'h4921, 1'b0,
                4'b0100, (c < 4) ? 4'h3 : 4'h9, 1'b1, 1'b0);

        // All requests gone: idle, blanked.
        cyc(1'b1, 4'b0000, 16'h4921, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b1);
        cyc(1'b1, 4'b0000, 16'h4921, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b0);

        // Grant to 0 (ptr was 3), then reset mid-dwell; ptr must restart at 0.
        cyc(1'b1, 4'b0001, 16'h4921, 1'b0, 4'b0001, 4'h1, 1'b1, 1'b1);
        cyc(1'b1, 4'b0011, 16'h4921, 1'b0, 4'b0001, 4'h1, 1'b1, 1'b0);
        cyc(1'b0, 4'b0011, 16'h4921, 1'b0, 4'b0000, 4'h0, 1'b1, 1'b0);
        cyc(1'b1, 4'b0011, 16'h4921, 1'b0, 4'b0001, 4'h1, 1'b1, 1'b1);

        // Source 1 asserted mid-dwell waits for its turn.
        repeat (3) cyc(1'b1, 4'b0011, 16'h4921, 1'b0, 4'b0001, 4'h1, 1'b1, 1'b0);
        cyc(1'b1, 4'b0011, 16'h4921, 1'b0, 4'b0010, 4'h2, 1'b1, 1'b1);

        // Owner drop under hold still switches; then everything released.
        cyc(1'b1, 4'b0001, 16'h4921, 1'b1, 4'b0001, 4'h1, 1'b1, 1'b1);
        cyc(1'b1, 4'b0000, 16'h4921, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b1);
`else
        // Blank gap of 2 cycles between every change of owner; digit holds.
        for (int rep = 0; rep < 2; rep++) begin
            for (int c = 0; c < 4; c++)
                cyc(1'b1, 4'b0011, 16'h4321, 1'b0, 4'b0001, 4'h1, 1'b1, c == 0);
            cyc(1'b1, 4'b0011, 16'h4321, 1'b0, 4'b0000, 4'h1, 1'b1, 1'b1);
            cyc(1'b1, 4'b0011, 16'h4321, 1'b0, 4'b0000, 4'h1, 1'b1, 1'b0);
            for (int c = 0; c < 4; c++)
                cyc(1'b1, 4'b0011, 16'h4321, 1'b0, 4'b0010, 4'h2, 1'b1, c == 0);
            cyc(1'b1, 4'b0011, 16'h4321, 1'b0, 4'b0000, 4'h2, 1'b1, 1'b1);
            cyc(1'b1, 4'b0011, 16'h4321, 1'b0, 4'b0000, 4'h2, 1'b1, 1'b0);
        end
        cyc(1'b1, 4'b0011, 16'h4321, 1'b0, 4'b0001, 4'h1, 1'b1, 1'b1);
        cyc(1'b1, 4'b0011, 16'h4321, 1'b0, 4'b0001, 4'h1, 1'b1, 1'b0);
        cyc(1'b0, 4'b0011, 16'h4321, 1'b0, 4'b0000, 4'h0, 1'b1, 1'b0);
        cyc(1'b1, 4'b0011, 16'h4321, 1'b0, 4'b0001, 4'h1, 1'b1, 1'b1);
`endif

        repeat (3) @(negedge clock);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
